// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - issue-side RAW/WAW hazard scoreboard for the 16-entry register file
// Optional SCOREBOARD_BYPASS_EN: a source whose last pending write retires this cycle does not stall.
module reg_scoreboard #(
  parameter int NUM_REGS    = 16,
  parameter int CNT_W       = 2,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  input  logic                   issue_wb_en,
  input  logic [3:0]             issue_dest,
  input  logic [3:0]             src1,
  input  logic [3:0]             src2,
  input  logic                   use_src2,
  input  logic                   writeBackEn,
  input  logic [3:0]             destWB,
  input  logic                   squash_valid,
  input  logic [3:0]             squash_dest,
  output logic                   hazard,
  output logic                   issue_fire,
  output logic [NUM_REGS-1:0]    busy_mask,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic                   sb_err
);

  localparam int SUM_W = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt      [NUM_REGS];
  logic [CNT_W-1:0] cnt_next [NUM_REGS];
  logic             err_next;
  logic             pend1, pend2, dest_full;
  logic [SUM_W-1:0] up, dn, diff;
  logic             inc, ret, sq;

  always_comb begin
    pend1 = cnt[src1] != '0;
    pend2 = cnt[src2] != '0;
`ifdef SCOREBOARD_BYPASS_EN
    // Register file commits on negedge, so the last retiring write is visible to this read.
    if (cnt[src1] == CNT_W'(1) && writeBackEn && destWB == src1) pend1 = 1'b0;
    if (cnt[src2] == CNT_W'(1) && writeBackEn && destWB == src2) pend2 = 1'b0;
`endif
    dest_full  = cnt[issue_dest] == CNT_MAX;
    hazard     = issue_valid & (pend1 | (use_src2 & pend2) | (issue_wb_en & dest_full));
    issue_fire = issue_valid & ~hazard;
  end

  // Issue, retire and squash may all hit one register; they net out arithmetically.
  always_comb begin
    err_next  = 1'b0;
    busy_mask = '0;
    up        = '0;
    dn        = '0;
    diff      = '0;
    inc       = 1'b0;
    ret       = 1'b0;
    sq        = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc  = issue_fire & issue_wb_en & (issue_dest == 4'(r));
      ret  = writeBackEn & (destWB == 4'(r));
      sq   = squash_valid & (squash_dest == 4'(r));
      up   = {2'b00, cnt[r]} + SUM_W'(inc);
      dn   = SUM_W'(ret) + SUM_W'(sq);
      diff = up - dn;
      if (dn > up) begin
        cnt_next[r] = '0;
        err_next    = 1'b1;
      end else if (diff > {2'b00, CNT_MAX}) begin
        cnt_next[r] = CNT_MAX;
        err_next    = 1'b1;
      end else begin
        cnt_next[r] = diff[CNT_W-1:0];
      end
      busy_mask[r] = cnt[r] != '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      stall_cnt <= '0;
      sb_err    <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= cnt_next[r];
      if (hazard && stall_cnt != '1) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      if (err_next) sb_err <= 1'b1;
    end
  end

endmodule
